// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory / load-store unit.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} dmem_size_t;

  typedef enum logic {ST_IDLE, ST_RESP} dmem_state_t;

  // Byte-lane enable for an access of the given size starting at the given lane.
  function automatic logic [7:0] be_mask(dmem_size_t size, logic [2:0] offset);
    logic [7:0] m;
    unique case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake bundle between the core MEM stage and dmem_lsu.
interface dmem_lsu_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024
);
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH) + $clog2(DATA_WIDTH / 8);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with per-byte write enable and registered read (no reset).
module dmem_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [DATA_WIDTH/8-1:0]      be,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Read data only updates on a read, so it stays stable while a response is held.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit front-end over byte-lane RAM. Optional counters via DMEM_LSU_PERF_EN.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic        clk,
  input  logic        RESET,
  dmem_lsu_if.slave   bus
`ifdef DMEM_LSU_PERF_EN
  ,
  output logic [15:0] perf_loads,
  output logic [15:0] perf_stores,
  output logic [15:0] perf_errs
`endif
);
  localparam int unsigned NB         = DATA_WIDTH / 8;
  localparam int unsigned OFFW       = $clog2(NB);
  localparam int unsigned IDXW       = $clog2(MEM_DEPTH);
  localparam int unsigned ADDR_WIDTH = IDXW + OFFW;

  dmem_state_t           state_q, state_d;
  dmem_size_t            size_in, size_q;
  logic [OFFW-1:0]       off_in, off_q;
  logic [IDXW-1:0]       idx_in;
  logic                  accept, legal;
  logic                  we_q, uns_q, err_q;
  logic [2:0]            align_mask;
  logic [7:0]            be_full;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata_lane, ram_rdata, load_shift, load_ext;
  logic                  sign_bit;

  assign size_in = dmem_size_t'(bus.req_size);
  assign off_in  = bus.req_addr[OFFW-1:0];
  assign idx_in  = bus.req_addr[ADDR_WIDTH-1:OFFW];

  always_comb begin
    align_mask = 3'b000;
    unique case (size_in)
      SZ_B:    align_mask = 3'b000;
      SZ_H:    align_mask = 3'b001;
      SZ_W:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    legal = ((3'(off_in) & align_mask) == 3'b000) && ((size_in != SZ_D) || (DATA_WIDTH == 64));
  end

  assign be_full    = be_mask(size_in, 3'(off_in));
  assign be         = be_full[NB-1:0];
  assign wdata_lane = bus.req_wdata << {off_in, 3'b000};

  assign bus.req_ready = (state_q == ST_IDLE) || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_RESP;
    end else if ((state_q == ST_RESP) && bus.rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      size_q  <= SZ_B;
      off_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q <= size_in;
        off_q  <= off_in;
        we_q   <= bus.req_we;
        uns_q  <= bus.req_unsigned;
        err_q  <= !legal;
      end
    end
  end

  dmem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk  (clk),
    .en   (accept && legal),
    .we   (bus.req_we),
    .be   (be),
    .addr (idx_in),
    .wdata(wdata_lane),
    .rdata(ram_rdata)
  );

  // Extension is applied on the held RAM word, so rsp_rdata is stable under backpressure.
  assign load_shift = ram_rdata >> {off_q, 3'b000};

  always_comb begin
    sign_bit = 1'b0;
    unique case (size_q)
      SZ_B:    sign_bit = load_shift[7];
      SZ_H:    sign_bit = load_shift[15];
      SZ_W:    sign_bit = load_shift[31];
      default: sign_bit = load_shift[DATA_WIDTH-1];
    endcase
    load_ext = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      load_ext[i] = (i < (8 << size_q)) ? load_shift[i] : (!uns_q && sign_bit);
    end
  end

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = bus.rsp_valid && err_q;
  assign bus.rsp_rdata = (bus.rsp_valid && !we_q && !err_q) ? load_ext : '0;

`ifdef DMEM_LSU_PERF_EN
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errs   <= '0;
    end else if (accept) begin
      if (!legal) begin
        if (perf_errs != 16'hFFFF) perf_errs <= perf_errs + 16'd1;
      end else if (bus.req_we) begin
        if (perf_stores != 16'hFFFF) perf_stores <= perf_stores + 16'd1;
      end else begin
        if (perf_loads != 16'hFFFF) perf_loads <= perf_loads + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu (DATA_WIDTH=32); honours DMEM_LSU_PERF_EN.
module tb_dmem_lsu;
  logic clk;
  logic RESET;
  int   n_checks;
  int   n_errors;

  dmem_lsu_if #(.DATA_WIDTH(32), .MEM_DEPTH(1024)) bus ();

`ifdef DMEM_LSU_PERF_EN
  logic [15:0] perf_loads, perf_stores, perf_errs;
`endif

  dmem_lsu #(
    .DATA_WIDTH(32),
    .MEM_DEPTH (1024)
  ) u_dut (
    .clk  (clk),
    .RESET(RESET),
    .bus  (bus)
`ifdef DMEM_LSU_PERF_EN
    ,
    .perf_loads (perf_loads),
    .perf_stores(perf_stores),
    .perf_errs  (perf_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  // Single transaction: accept on one edge, response must be valid right after it.
  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    drive(we, size, uns, addr, wdata);
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check_eq({tag, ".vld"}, 64'(bus.rsp_valid), 64'd1);
    check_eq({tag, ".err"}, 64'(bus.rsp_err), 64'(exp_err));
    check_eq({tag, ".data"}, 64'(bus.rsp_rdata), 64'(exp_rdata));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    RESET = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 12'h0, 32'h0);
    repeat (2) @(negedge clk);
    check_eq("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst.rsp_err", 64'(bus.rsp_err), 64'd0);
    check_eq("rst.rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check_eq("rst.req_ready", 64'(bus.req_ready), 64'd1);
`ifdef DMEM_LSU_PERF_EN
    check_eq("rst.perf_loads", 64'(perf_loads), 64'd0);
    check_eq("rst.perf_stores", 64'(perf_stores), 64'd0);
    check_eq("rst.perf_errs", 64'(perf_errs), 64'd0);
`endif
    RESET = 1'b1;

    // Word store / load
    xact("sw10", 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lw10", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    // Sub-word loads with extension
    xact("lb13", 1'b0, 2'd0, 1'b0, 12'h013, 32'h0, 32'hFFFFFFDE, 1'b0);
    xact("lbu13", 1'b0, 2'd0, 1'b1, 12'h013, 32'h0, 32'h000000DE, 1'b0);
    xact("lh10", 1'b0, 2'd1, 1'b0, 12'h010, 32'h0, 32'hFFFFBEEF, 1'b0);
    xact("lhu10", 1'b0, 2'd1, 1'b1, 12'h010, 32'h0, 32'h0000BEEF, 1'b0);
    // Sub-word stores; upper wdata bits must be ignored
    xact("sb11", 1'b1, 2'd0, 1'b0, 12'h011, 32'hAAAAAA55, 32'h0, 1'b0);
    xact("lw_sb", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'hDEAD55EF, 1'b0);
    xact("sh12", 1'b1, 2'd1, 1'b0, 12'h012, 32'hCCCC1234, 32'h0, 1'b0);
    xact("lw_sh", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'h123455EF, 1'b0);
    // Misaligned and illegal size
    xact("lw12_mis", 1'b0, 2'd2, 1'b0, 12'h012, 32'h0, 32'h0, 1'b1);
    xact("sh11_mis", 1'b1, 2'd1, 1'b0, 12'h011, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("lw_unchg", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'h123455EF, 1'b0);
    xact("ld_sz3", 1'b0, 2'd3, 1'b0, 12'h010, 32'h0, 32'h0, 1'b1);
`ifdef DMEM_LSU_PERF_EN
    check_eq("perf_loads", 64'(perf_loads), 64'd8);
    check_eq("perf_stores", 64'(perf_stores), 64'd3);
    check_eq("perf_errs", 64'(perf_errs), 64'd3);
`endif

    // Backpressure: LW held for 3 cycles while LB waits at the request port
    @(negedge clk);
    drive(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp.req_ready", 64'(bus.req_ready), 64'd0);
      check_eq("bp.rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check_eq("bp.rsp_rdata", 64'(bus.rsp_rdata), 64'h123455EF);
      check_eq("bp.rsp_err", 64'(bus.rsp_err), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("b2b1.vld", 64'(bus.rsp_valid), 64'd1);
    check_eq("b2b1.data", 64'(bus.rsp_rdata), 64'h00000012);
    drive(1'b0, 2'd1, 1'b1, 12'h010, 32'h0);
    @(posedge clk);
    #1;
    check_eq("b2b2.vld", 64'(bus.rsp_valid), 64'd1);
    check_eq("b2b2.data", 64'(bus.rsp_rdata), 64'h000055EF);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("b2b.idle", 64'(bus.rsp_valid), 64'd0);

    // Reset mid-response drops the response
    @(negedge clk);
    drive(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check_eq("rstmid.pre_vld", 64'(bus.rsp_valid), 64'd1);
    RESET = 1'b0;
    #1;
    check_eq("rstmid.vld", 64'(bus.rsp_valid), 64'd0);
    check_eq("rstmid.data", 64'(bus.rsp_rdata), 64'd0);
    @(negedge clk);
    RESET = 1'b1;

    // Store accepted before reset stays committed
    @(negedge clk);
    drive(1'b1, 2'd0, 1'b0, 12'h010, 32'h000000AA);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    RESET = 1'b0;
    @(negedge clk);
    RESET = 1'b1;
    xact("lw_rststore", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'h123455AA, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
